trace_word_serialiser: RTL and testbench

Sits directly downstream of the writeback tracker. Consumes completed trace_output elements, each presented as a one-cycle ready pulse. Buffers them in a small FIFO. Serialises each element into a fixed sequence of 32-bit words on a valid/ready stream for an off-chip trace port (UART/DMA bridge), counting and flagging elements lost to overflow.

---
 rtl/trace_word_serialiser_pkg.sv | 92 +++++++++
 rtl/trace_word_serialiser_fifo.sv | 63 ++++++
 rtl/trace_word_serialiser.sv | 168 ++++++++++++++++
 tb/tb_trace_word_serialiser.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_word_serialiser_pkg.sv
// Shared trace datatypes, packet constants and the packet word generator.
// TRACE_SERIALISER_CHECKSUM_EN selects the 10-word packet with trailing XOR checksum.
package ryuki_datatypes;

    typedef struct packed {
        logic [31:0] time_start;
        logic [31:0] time_end;
    } mem_access_time_t;

    typedef struct packed {
        logic [31:0]      time_start;
        logic [31:0]      time_end;
        mem_access_time_t mem_access_req;
    } ex_trace_t;

    typedef struct packed {
        logic [31:0]      time_start;
        logic [31:0]      time_end;
        mem_access_time_t mem_access_res;
    } wb_trace_t;

    typedef struct packed {
        logic      pass_through;
        ex_trace_t ex_data;
        wb_trace_t wb_data;
    } trace_output;

    localparam logic [7:0] TRACE_HDR_MAGIC   = 8'hA5;
    localparam int         TRACE_PKT_WORDS   = 9;
    localparam int         TRACE_FLAG_PASS   = 0;
    localparam int         TRACE_FLAG_DROP   = 1;
    localparam int         TRACE_FLAG_WB_RES = 2;
    localparam int         TRACE_FLAG_EX_REQ = 3;

`ifdef TRACE_SERIALISER_CHECKSUM_EN
    localparam logic [3:0] TRACE_FMT_VERSION = 4'h1;
    localparam int         TRACE_PKT_LEN     = TRACE_PKT_WORDS + 1;
`else
    localparam logic [3:0] TRACE_FMT_VERSION = 4'h0;
    localparam int         TRACE_PKT_LEN     = TRACE_PKT_WORDS;
`endif

    typedef struct packed {
        logic [7:0]  magic;
        logic [7:0]  flags;
        logic [15:0] seq;
    } trace_hdr_t;

    typedef struct packed {
        trace_output elem;
        logic [15:0] seq;
        logic        drop_before;
    } trace_fifo_entry_t;

    // Word idx of the packet for entry e; the index past the data words is the XOR checksum.
    function automatic logic [31:0] trace_pkt_word(input trace_fifo_entry_t e, input logic [3:0] idx);
        logic [31:0] w [TRACE_PKT_WORDS];
        trace_hdr_t  hdr;
        logic [31:0] res;
        hdr.magic                    = TRACE_HDR_MAGIC;
        hdr.flags                    = 8'h00;
        hdr.flags[7:4]               = TRACE_FMT_VERSION;
        hdr.flags[TRACE_FLAG_PASS]   = e.elem.pass_through;
        hdr.flags[TRACE_FLAG_DROP]   = e.drop_before;
        hdr.flags[TRACE_FLAG_WB_RES] = (e.elem.wb_data.mem_access_res.time_end != 32'd0);
        hdr.flags[TRACE_FLAG_EX_REQ] = (e.elem.ex_data.mem_access_req.time_end != 32'd0);
        hdr.seq                      = e.seq;
        w[0] = hdr;
        w[1] = e.elem.ex_data.time_start;
        w[2] = e.elem.ex_data.time_end;
        w[3] = e.elem.ex_data.mem_access_req.time_start;
        w[4] = e.elem.ex_data.mem_access_req.time_end;
        w[5] = e.elem.wb_data.time_start;
        w[6] = e.elem.wb_data.time_end;
        w[7] = e.elem.wb_data.mem_access_res.time_start;
        w[8] = e.elem.wb_data.mem_access_res.time_end;
        res  = 32'h0000_0000;
        if (idx < 4'd9) begin
            res = w[idx];
        end else begin
`ifdef TRACE_SERIALISER_CHECKSUM_EN
            for (int i = 0; i < TRACE_PKT_WORDS; i++) begin
                res = res ^ w[i];
            end
`else
            res = 32'h0000_0000;
`endif
        end
        return res;
    endfunction

endpackage

// File: rtl/trace_word_serialiser_fifo.sv
// trace_elem_fifo: circular buffer of tagged trace elements; push while full is
// accepted only when a pop happens in the same cycle.
module trace_elem_fifo
    import ryuki_datatypes::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  trace_fifo_entry_t            push_data,
    input  logic                         pop,
    output trace_fifo_entry_t            pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    trace_fifo_entry_t mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == {LW{1'b0}});
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/trace_word_serialiser.sv
// Buffers completed trace elements and serialises each into a fixed packet of
// 32-bit words on a valid/ready stream. TRACE_SERIALISER_CHECKSUM_EN adds a checksum word.
module trace_word_serialiser
    import ryuki_datatypes::*;
#(
    parameter int DEPTH      = 8,
    parameter int DROP_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trace_valid_i,
    input  trace_output                 trace_i,
    output logic [31:0]                 word_o,
    output logic                        word_valid_o,
    input  logic                        word_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_level_o,
    output logic [DROP_CNT_W-1:0]       drop_count_o,
    output logic                        busy_o
);
    localparam logic [3:0] LAST_IDX = 4'(TRACE_PKT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [3:0]        idx_r, idx_nxt_s;
    trace_fifo_entry_t pkt_r, pkt_nxt_s;
    logic [31:0]       word_r, word_nxt_s;
    logic              word_valid_r, word_valid_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic [15:0]       seq_r;
    logic              drop_pend_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;
    logic              pop_s, accept_s, drop_s;
    logic              fifo_full_s, fifo_empty_s;
    trace_fifo_entry_t push_entry_s, head_s;

    // New elements carry the running sequence number and whether a loss preceded them.
    always_comb begin
        push_entry_s.elem        = trace_i;
        push_entry_s.seq         = seq_r;
        push_entry_s.drop_before = drop_pend_r;
    end

    // A full FIFO still accepts when the FSM pops in the same cycle.
    always_comb begin
        accept_s = 1'b0;
        drop_s   = 1'b0;
        if (trace_valid_i) begin
            if (!fifo_full_s || pop_s) begin
                accept_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
    end

    trace_elem_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .level     (fifo_level_o),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Sequence numbering, drop-pending flag and saturating loss counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_r       <= 16'd0;
            drop_pend_r <= 1'b0;
            drop_cnt_r  <= {DROP_CNT_W{1'b0}};
        end else if (accept_s) begin
            seq_r       <= seq_r + 16'd1;
            drop_pend_r <= 1'b0;
        end else if (drop_s) begin
            drop_pend_r <= 1'b1;
            if (drop_cnt_r != {DROP_CNT_W{1'b1}}) begin
                drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
            end
        end
    end

    // Next-state and next-output logic; the header is taken straight from the FIFO head in LOAD.
    always_comb begin
        state_nxt_s      = state_r;
        idx_nxt_s        = idx_r;
        pkt_nxt_s        = pkt_r;
        word_nxt_s       = word_r;
        word_valid_nxt_s = word_valid_r;
        pop_s            = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                pop_s            = 1'b1;
                pkt_nxt_s        = head_s;
                idx_nxt_s        = 4'd0;
                word_nxt_s       = trace_pkt_word(head_s, 4'd0);
                word_valid_nxt_s = 1'b1;
                state_nxt_s      = S_EMIT;
            end
            S_EMIT: begin
                if (word_ready_i) begin
                    if (idx_r == LAST_IDX) begin
                        word_valid_nxt_s = 1'b0;
                        word_nxt_s       = 32'h0000_0000;
                        if (fifo_empty_s) begin
                            state_nxt_s = S_IDLE;
                        end else begin
                            state_nxt_s = S_LOAD;
                        end
                    end else begin
                        idx_nxt_s  = idx_r + 4'd1;
                        word_nxt_s = trace_pkt_word(pkt_r, idx_r + 4'd1);
                    end
                end else begin
                    state_nxt_s = S_EMIT;
                end
            end
            default: begin
                state_nxt_s      = S_IDLE;
                word_valid_nxt_s = 1'b0;
                word_nxt_s       = 32'h0000_0000;
            end
        endcase
        busy_nxt_s = (state_nxt_s != S_IDLE) || !fifo_empty_s || accept_s;
    end

    // State and registered stream outputs; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            idx_r        <= 4'd0;
            pkt_r        <= '0;
            word_r       <= 32'h0000_0000;
            word_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            idx_r        <= idx_nxt_s;
            pkt_r        <= pkt_nxt_s;
            word_r       <= word_nxt_s;
            word_valid_r <= word_valid_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign word_o       = word_r;
    assign word_valid_o = word_valid_r;
    assign drop_count_o = drop_cnt_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_trace_word_serialiser.sv
// Directed scoreboard bench for trace_word_serialiser; honours TRACE_SERIALISER_CHECKSUM_EN.
module tb_trace_word_serialiser;
    import ryuki_datatypes::*;

    localparam int DEPTH = 8;
    localparam int DCW   = 16;
`ifdef TRACE_SERIALISER_CHECKSUM_EN
    localparam logic [31:0] HDR_T1 = 32'hA510_0000;
    localparam int          NWORDS = 10;
`else
    localparam logic [31:0] HDR_T1 = 32'hA500_0000;
    localparam int          NWORDS = 9;
`endif

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         trace_valid_i;
    trace_output                  trace_i;
    logic [31:0]                  word_o;
    logic                         word_valid_o;
    logic                         word_ready_i;
    logic [$clog2(DEPTH+1)-1:0]   fifo_level_o;
    logic [DCW-1:0]               drop_count_o;
    logic                         busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] prev_word;
    logic        prev_hold = 1'b0;

    trace_word_serialiser #(.DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
        .clk           (clk),
        .rst           (rst),
        .trace_valid_i (trace_valid_i),
        .trace_i       (trace_i),
        .word_o        (word_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .fifo_level_o  (fifo_level_o),
        .drop_count_o  (drop_count_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic trace_output mk(input logic pass,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d,
                                       input logic [31:0] f, input logic [31:0] g,
                                       input logic [31:0] h, input logic [31:0] k);
        trace_output t;
        t.pass_through                       = pass;
        t.ex_data.time_start                 = a;
        t.ex_data.time_end                   = b;
        t.ex_data.mem_access_req.time_start  = c;
        t.ex_data.mem_access_req.time_end    = d;
        t.wb_data.time_start                 = f;
        t.wb_data.time_end                   = g;
        t.wb_data.mem_access_res.time_start  = h;
        t.wb_data.mem_access_res.time_end    = k;
        return t;
    endfunction

    // Expected packet for element e accepted with sequence number seq.
    task automatic exp_push(input trace_output e, input logic [15:0] seq, input logic drop);
        logic [7:0]  flags;
        logic [31:0] w [10];
        flags    = 8'h00;
        flags[0] = e.pass_through;
        flags[1] = drop;
        flags[2] = (e.wb_data.mem_access_res.time_end != 32'd0);
        flags[3] = (e.ex_data.mem_access_req.time_end != 32'd0);
`ifdef TRACE_SERIALISER_CHECKSUM_EN
        flags[7:4] = 4'h1;
`endif
        w[0] = {8'hA5, flags, seq};
        w[1] = e.ex_data.time_start;
        w[2] = e.ex_data.time_end;
        w[3] = e.ex_data.mem_access_req.time_start;
        w[4] = e.ex_data.mem_access_req.time_end;
        w[5] = e.wb_data.time_start;
        w[6] = e.wb_data.time_end;
        w[7] = e.wb_data.mem_access_res.time_start;
        w[8] = e.wb_data.mem_access_res.time_end;
        w[9] = 32'd0;
        for (int i = 0; i < 9; i++) w[9] = w[9] ^ w[i];
        for (int i = 0; i < NWORDS; i++) exp_q.push_back(w[i]);
    endtask

    task automatic pulse(input trace_output e);
        trace_i       = e;
        trace_valid_i = 1'b1;
        @(posedge clk); #1;
        trace_valid_i = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy_o), 32'd0);
    endtask

    // Monitor: scoreboard compare on each transfer, plus hold-stability under back-pressure.
    initial begin
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", 32'(word_valid_o), 32'd1);
                    check("hold_word", word_o, prev_word);
                end
                if (word_valid_o === 1'b1 && word_ready_i === 1'b1) begin
                    check("pending_expect", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        check("word", word_o, w);
                    end
                end
                prev_hold = (word_valid_o === 1'b1) && (word_ready_i === 1'b0);
                prev_word = word_o;
            end
        end
    end

    initial begin
        trace_output e;
        int n;
        rst           = 1'b1;
        trace_valid_i = 1'b0;
        trace_i       = '0;
        word_ready_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(word_valid_o), 32'd0);
        check("rst_word", word_o, 32'd0);
        check("rst_level", 32'(fifo_level_o), 32'd0);
        check("rst_drop", 32'(drop_count_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single element, free-flowing consumer
        word_ready_i = 1'b1;
        e = mk(1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd8, 32'd10, 32'd0, 32'd0);
        exp_push(e, 16'd0, 1'b0);
        pulse(e);
        n = 0;
        while (!word_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        check("latency", 32'(n), 32'd2);
        check("first_header", word_o, HDR_T1);
        drain(200);
        check("t1_level", 32'(fifo_level_o), 32'd0);

        // Back-pressure on W2 with a pass-through element
        e = mk(1'b1, 32'h2222_0001, 32'h2222_0002, 32'd3, 32'd4, 32'd100, 32'd200, 32'hFFFF_FFFF, 32'd9);
        exp_push(e, 16'd1, 1'b0);
        pulse(e);
        n = 0;
        while (!(word_valid_o && word_o == 32'h2222_0001) && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_w1", word_o, 32'h2222_0001);
        @(posedge clk); #1;
        word_ready_i = 1'b0;
        check("bp_w2_c0", word_o, 32'h2222_0002);
        @(posedge clk); #1;
        check("bp_w2_c1", word_o, 32'h2222_0002);
        @(posedge clk); #1;
        check("bp_w2_c2", word_o, 32'h2222_0002);
        word_ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_w3", word_o, 32'd3);
        drain(200);

        // Overflow: one packet stalled in flight, then ten pulses into the FIFO
        word_ready_i = 1'b0;
        e = mk(1'b0, 32'h3000_0000, 32'h3000_0001, 32'd0, 32'd0, 32'd1, 32'd2, 32'd0, 32'd0);
        exp_push(e, 16'd2, 1'b0);
        pulse(e);
        repeat (3) begin @(posedge clk); #1; end
        check("ov_hold_valid", 32'(word_valid_o), 32'd1);
        check("ov_hold_level", 32'(fifo_level_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            e = mk(1'b0, 32'(1000 + i), 32'(2000 + i), 32'd0, 32'd0, 32'd3, 32'd4, 32'd0, 32'd0);
            if (i < 8) exp_push(e, 16'(3 + i), 1'b0);
            pulse(e);
        end
        check("ov_level", 32'(fifo_level_o), 32'd8);
        check("ov_drop", 32'(drop_count_o), 32'd2);
        word_ready_i = 1'b1;
        n = 0;
        while (word_valid_o && n < 50) begin @(posedge clk); #1; n++; end
        check("ov_load_gap", 32'(word_valid_o), 32'd0);
        // Push while full in the LOAD cycle: accepted, tagged with the earlier loss
        e = mk(1'b0, 32'h5000_0000, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd12);
        exp_push(e, 16'd11, 1'b1);
        pulse(e);
        check("full_pp_level", 32'(fifo_level_o), 32'd8);
        check("full_pp_drop", 32'(drop_count_o), 32'd2);
        drain(1000);
        check("ov_end_level", 32'(fifo_level_o), 32'd0);
        check("ov_end_drop", 32'(drop_count_o), 32'd2);

        // Reset while W4 is on the bus
        e = mk(1'b0, 32'd11, 32'd12, 32'd13, 32'h4444_0004, 32'd15, 32'd16, 32'd17, 32'd18);
        exp_push(e, 16'd12, 1'b0);
        pulse(e);
        n = 0;
        while (!(word_valid_o && word_o == 32'h4444_0004) && n < 20) begin @(posedge clk); #1; n++; end
        check("mid_w4", word_o, 32'h4444_0004);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(word_valid_o), 32'd0);
        check("mid_rst_word", word_o, 32'd0);
        check("mid_rst_level", 32'(fifo_level_o), 32'd0);
        check("mid_rst_drop", 32'(drop_count_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        e = mk(1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 32'd8, 32'd10, 32'd0, 32'd0);
        exp_push(e, 16'd0, 1'b0);
        pulse(e);
        n = 0;
        while (!word_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        check("post_rst_header", word_o, HDR_T1);
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
